// File: rtl/class_argmax_pkg.sv
// rtl/class_argmax_pkg.sv - shared FSM encodings for the class argmax block
package class_argmax_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/class_argmax_cmp.sv
// rtl/class_argmax_cmp.sv - one step of the running top-two search over signed sums
module argmax_cmp #(
    parameter int SUM_WIDTH = 16,
    parameter int IDX_WIDTH = 6
) (
    input  logic signed [SUM_WIDTH-1:0] i_x,
    input  logic signed [SUM_WIDTH-1:0] i_best,
    input  logic signed [SUM_WIDTH-1:0] i_second,
    input  logic        [IDX_WIDTH-1:0] i_ptr,
    input  logic        [IDX_WIDTH-1:0] i_idx,
    output logic signed [SUM_WIDTH-1:0] o_best,
    output logic signed [SUM_WIDTH-1:0] o_second,
    output logic        [IDX_WIDTH-1:0] o_idx
);

    // Strict greater-than keeps the earlier index on ties.
    always_comb begin
        o_best   = i_best;
        o_second = i_second;
        o_idx    = i_idx;
        if (i_x > i_best) begin
            o_second = i_best;
            o_best   = i_x;
            o_idx    = i_ptr;
        end else if (i_x > i_second) begin
            o_second = i_x;
        end
    end

endmodule

// File: rtl/class_argmax.sv
// rtl/class_argmax.sv - sequential argmax with score and winner margin over the network output sums
module class_argmax
    import class_argmax_pkg::*;
#(
    parameter int NUM_CLASSES = 4,
    parameter int SUM_WIDTH   = 16,
    parameter int IDX_WIDTH   = 6
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             product_rdy,
    input  logic [NUM_CLASSES*SUM_WIDTH-1:0] class_sums,
    output logic [IDX_WIDTH-1:0]             class_idx,
    output logic [SUM_WIDTH-1:0]             class_score,
    output logic [SUM_WIDTH-1:0]             class_margin,
    output logic                             result_valid,
    output logic                             busy,
    output logic                             overrun
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [SUM_WIDTH-1:0] MOST_NEG = {1'b1, {(SUM_WIDTH-1){1'b0}}};

    logic [1:0]                      r_state;
    logic [IDX_WIDTH-1:0]            r_ptr;
    logic [NUM_CLASSES*SUM_WIDTH-1:0] r_cap;
    logic signed [SUM_WIDTH-1:0]     r_best;
    logic signed [SUM_WIDTH-1:0]     r_second;
    logic [IDX_WIDTH-1:0]            r_idx;
    logic [IDX_WIDTH-1:0]            r_class_idx;
    logic [SUM_WIDTH-1:0]            r_class_score;
    logic [SUM_WIDTH-1:0]            r_class_margin;
    logic                            r_result_valid;
    logic                            r_overrun;

    logic signed [SUM_WIDTH-1:0]     w_x;
    logic signed [SUM_WIDTH-1:0]     w_next_best;
    logic signed [SUM_WIDTH-1:0]     w_next_second;
    logic [IDX_WIDTH-1:0]            w_next_idx;
    logic [SUM_WIDTH-1:0]            w_margin;

    // Selects the captured sum addressed by the scan pointer.
    always_comb begin
        w_x = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (r_ptr == IDX_WIDTH'(i)) begin
                w_x = r_cap[i*SUM_WIDTH +: SUM_WIDTH];
            end
        end
    end

    argmax_cmp #(
        .SUM_WIDTH (SUM_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_cmp (
        .i_x      (w_x),
        .i_best   (r_best),
        .i_second (r_second),
        .i_ptr    (r_ptr),
        .i_idx    (r_idx),
        .o_best   (w_next_best),
        .o_second (w_next_second),
        .o_idx    (w_next_idx)
    );

    // best >= second, so the one-bit-wider difference is non-negative and its
    // low SUM_WIDTH bits equal the modular SUM_WIDTH subtraction taken here.
    assign w_margin = r_best - r_second;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_cap          <= '0;
            r_best         <= '0;
            r_second       <= '0;
            r_idx          <= '0;
            r_class_idx    <= '0;
            r_class_score  <= '0;
            r_class_margin <= '0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (product_rdy) begin
                        r_cap    <= class_sums;
                        r_best   <= class_sums[SUM_WIDTH-1:0];
                        r_second <= MOST_NEG;
                        r_idx    <= '0;
                        r_ptr    <= IDX_WIDTH'(1);
                        r_state  <= (NUM_CLASSES == 1) ? ST_DONE : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_best   <= w_next_best;
                    r_second <= w_next_second;
                    r_idx    <= w_next_idx;
                    if (r_ptr == LAST_IDX) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_ptr <= r_ptr + IDX_WIDTH'(1);
                    end
                    if (product_rdy) begin
                        r_overrun <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_class_idx    <= r_idx;
                    r_class_score  <= r_best;
                    r_class_margin <= (NUM_CLASSES == 1) ? '0 : w_margin;
                    r_result_valid <= 1'b1;
                    r_state        <= ST_IDLE;
                    if (product_rdy) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign class_idx    = r_class_idx;
    assign class_score  = r_class_score;
    assign class_margin = r_class_margin;
    assign result_valid = r_result_valid;
    assign busy         = (r_state != ST_IDLE);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_class_argmax.sv
// tb/tb_class_argmax.sv - randomized scoreboard bench for class_argmax
module tb_class_argmax;

    localparam int NC = 4;
    localparam int SW = 16;
    localparam int IW = 6;

    typedef struct {
        int idx;
        int score;
        int margin;
        int cyc;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              product_rdy = 1'b0;
    logic [NC*SW-1:0]  class_sums = '0;
    logic [IW-1:0]     class_idx;
    logic [SW-1:0]     class_score;
    logic [SW-1:0]     class_margin;
    logic              result_valid;
    logic              busy;
    logic              overrun;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    class_argmax #(
        .NUM_CLASSES (NC),
        .SUM_WIDTH   (SW),
        .IDX_WIDTH   (IW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .product_rdy  (product_rdy),
        .class_sums   (class_sums),
        .class_idx    (class_idx),
        .class_score  (class_score),
        .class_margin (class_margin),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NC*SW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [NC*SW-1:0] s;
        s = {d[15:0], c[15:0], b[15:0], a[15:0]};
        return s;
    endfunction

    // Winner = first occurrence of the maximum; runner-up = largest of the remaining entries.
    function automatic exp_t model(input logic [NC*SW-1:0] s, input int e0);
        int   v[NC];
        int   w;
        int   sec;
        exp_t e;
        for (int i = 0; i < NC; i++) begin
            v[i] = int'($signed(s[i*SW +: SW]));
        end
        w = 0;
        for (int i = 1; i < NC; i++) if (v[i] > v[w]) w = i;
        sec = -100000;
        for (int i = 0; i < NC; i++) if (i != w && v[i] > sec) sec = v[i];
        e.idx    = w;
        e.score  = v[w];
        e.margin = (v[w] - sec) & 16'hFFFF;
        e.cyc    = e0 + NC;
        return e;
    endfunction

    task automatic start(input logic [NC*SW-1:0] s, input bit expect_result);
        class_sums  = s;
        product_rdy = 1'b1;
        @(posedge clock);
        #1;
        product_rdy = 1'b0;
        class_sums  = {$urandom, $urandom};
        if (expect_result) sb_q.push_back(model(s, cyc));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (busy) chk("busy_timeout", 1, 0);
    endtask

    always @(negedge clock) begin
        if (result_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("class_idx", class_idx, e.idx);
                chk("class_score", $signed(class_score), e.score);
                chk("class_margin", class_margin, e.margin);
                chk("result_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        logic [NC*SW-1:0] s;
        int n;

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_idx", class_idx, 0);
        chk("rst_score", class_score, 0);
        chk("rst_margin", class_margin, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        start(pack4(5, -3, 12, 7), 1);
        chk("busy_scan", busy, 1);
        wait_idle();
        start(pack4(9, 9, 1, 0), 1);
        wait_idle();
        start(pack4(-8, -2, -2, -100), 1);
        wait_idle();
        start(pack4(32767, -32768, -32768, -32768), 1);
        wait_idle();
        @(posedge clock);
        #1;
        chk("busy_idle", busy, 0);
        chk("overrun_clear", overrun, 0);
        chk("hold_idx", class_idx, 0);
        chk("hold_margin", class_margin, 65535);

        // second pulse while scanning is dropped
        start(pack4(1, 50, 3, 2), 1);
        @(posedge clock);
        #1;
        class_sums  = pack4(100, 200, 300, 400);
        product_rdy = 1'b1;
        @(posedge clock);
        #1;
        product_rdy = 1'b0;
        wait_idle();
        repeat (4) @(posedge clock);
        #1;
        chk("overrun_set", overrun, 1);
        chk("no_restart", busy, 0);
        chk("first_result_kept", class_idx, 1);

        // reset in the middle of a scan aborts silently
        start(pack4(7, 6, 5, 4), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_idx", class_idx, 0);
        chk("abort_score", class_score, 0);
        chk("abort_margin", class_margin, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
        @(posedge clock);
        #1;
        chk("abort_valid", result_valid, 0);
        reset = 1'b1;
        start(pack4(1, 2, 3, 4), 1);
        wait_idle();
        @(posedge clock);
        #1;
        chk("post_rst_overrun", overrun, 0);

        // pulse landing on the DONE cycle is dropped
        start(pack4(-1, -5, 20, 19), 1);
        repeat (3) @(posedge clock);
        #1;
        class_sums  = pack4(0, 0, 0, 99);
        product_rdy = 1'b1;
        @(posedge clock);
        #1;
        product_rdy = 1'b0;
        @(posedge clock);
        #1;
        chk("done_drop_busy", busy, 0);
        chk("done_drop_overrun", overrun, 1);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < NC; i++) begin
                    n = int'($urandom_range(0, 3)) - 2;
                    s[i*SW +: SW] = n[15:0];
                end
            end else begin
                s = {$urandom, $urandom};
            end
            start(s, 1);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("scoreboard_drain", sb_q.size(), 0);
        chk("overrun_sticky", overrun, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
